// File: rtl/poly_nco_bank.sv
// poly_nco_bank: a bank of VOICES phase-accumulator voices. The voices are evaluated
// one after another once per audio sample. Each voice output is scaled by its amplitude,
// the results are summed, and the sum is saturated to a single signed AW-bit sample.
//  Clk, Reset_n       clock, async active-low reset
//  sample_tick        one-cycle strobe per audio sample; starts a frame when IDLE
//  wave_sel           00 saw, 01 square, 10 triangle, 11 silent
//  cmd_*              valid/ready note on/off command port (ready only in IDLE)
//  out, out_valid     mixed saturated sample; pulse while in DONE
//  voice_active       per-voice gate flags
//  overrun            sticky: tick seen while a frame was in progress

// Per-voice state: frequency word, amplitude, phase accumulator, gate.
module poly_nco_voice #(
  parameter int FW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,     // note on (also retrigger)
  input  logic          off,      // note off
  input  logic          adv,      // this voice's RUN slot
  input  logic [FW-1:0] freq_in,
  input  logic [7:0]    amp_in,
  output logic [15:0]   ptop,
  output logic [7:0]    amp,
  output logic          active
);
  logic [FW-1:0] phase, freq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      freq   <= '0;
      amp    <= '0;
      active <= 1'b0;
    end else if (load) begin
      freq   <= freq_in;
      amp    <= amp_in;
      phase  <= '0;
      active <= 1'b1;
    end else begin
      if (off)           active <= 1'b0;
      if (adv && active) phase  <= phase + freq;  // wraps mod 2^FW
    end
  end

  assign ptop = phase[FW-1 -: 16];
endmodule

module poly_nco_bank #(
  parameter int VOICES = 4,
  parameter int FW     = 24,
  parameter int AW     = 16,
  localparam int VI    = $clog2(VOICES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sample_tick,
  input  logic [1:0]        wave_sel,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_on,
  input  logic [VI-1:0]     cmd_voice,
  input  logic [FW-1:0]     cmd_freq,
  input  logic [7:0]        cmd_amp,
  output logic [AW-1:0]     out,
  output logic              out_valid,
  output logic [VOICES-1:0] voice_active,
  output logic              overrun
);
  localparam int ACCW = AW + VI;
  localparam logic [VI-1:0] LAST = VI'(VOICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nstate;

  logic [VI-1:0]              vidx;
  logic signed [ACCW-1:0]     acc, acc_next, contrib;
  logic [VOICES-1:0][15:0]    ptop;
  logic [VOICES-1:0][7:0]     amp;
  logic                       take;

  assign cmd_ready = (state == IDLE);
  assign take      = cmd_valid & cmd_ready;
  assign out_valid = (state == DONE);

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    poly_nco_voice #(.FW(FW)) u_voice (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .load   (take &  cmd_on & (cmd_voice == VI'(v))),
      .off    (take & ~cmd_on & (cmd_voice == VI'(v))),
      .adv    ((state == RUN) && (vidx == VI'(v))),
      .freq_in(cmd_freq),
      .amp_in (cmd_amp),
      .ptop   (ptop[v]),
      .amp    (amp[v]),
      .active (voice_active[v])
    );
  end

  // Shared waveform + scale datapath for the voice in the current slot.
  logic [15:0]        p;
  logic [14:0]        tri_t;
  logic signed [15:0] wave;
  logic signed [23:0] prod, shifted;

  always_comb begin
    p     = ptop[vidx];
    tri_t = p[15] ? ~p[14:0] : p[14:0];
    wave  = '0;
    case (wave_sel)
      2'b00:   wave = $signed(p - 16'h8000);
      2'b01:   wave = p[15] ? 16'sh8000 : 16'sh7FFF;
      2'b10:   wave = $signed({tri_t, 1'b0} - 16'h8000);
      default: wave = '0;
    endcase
    prod     = 24'(wave) * 24'($signed({1'b0, amp[vidx]}));
    shifted  = prod >>> 8;
    contrib  = voice_active[vidx] ? ACCW'(shifted) : '0;
    acc_next = acc + contrib;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (sample_tick) nstate = RUN;
      RUN:     if (vidx == LAST) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nstate;
  end

  // out is written on the final RUN slot so it is already visible while DONE
  // asserts out_valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc     <= '0;
      vidx    <= '0;
      out     <= '0;
      overrun <= 1'b0;
    end else begin
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          acc  <= '0;
          vidx <= '0;
        end
        RUN: begin
          acc  <= acc_next;
          vidx <= vidx + VI'(1);
          if (vidx == LAST) begin
            if (acc_next[ACCW-1:AW-1] != {(VI+1){acc_next[ACCW-1]}})
              out <= acc_next[ACCW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            else
              out <= acc_next[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
